// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder for the NES CPU bus. It decodes the CPU address into
// 2 KB of mirrored internal RAM, a mirrored PRG ROM image and the OAM DMA
// trigger register, and returns registered read data. A write to the DMA
// register stalls the CPU and copies one 256-byte page to OAM.
//
// Ports:
//   clk_ph2        single clock, rising edge
//   rst            synchronous active-high reset
//   Addr_bus       CPU address
//   cpu_rw         1 = read, 0 = write
//   cpu_dout       CPU write data
//   Data_bus       registered read data (one cycle after the address)
//   cpu_rdy        0 stalls the CPU (low for the whole DMA)
//   dma_busy       1 while a DMA transfer is in progress
//   oam_addr       OAM write index
//   oam_data       OAM write data
//   oam_we         OAM write strobe, one cycle per byte
//   prg_load_we    PRG ROM load strobe (honoured in every state)
//   prg_load_addr  PRG ROM load address
//   prg_load_data  PRG ROM load data
module cpu_mem_responder #(
  parameter int          RAM_AW  = 11,
  parameter int          PRG_AW  = 14,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        Data_bus,
  output logic              cpu_rdy,
  output logic              dma_busy,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_data,
  output logic              oam_we,
  input  logic              prg_load_we,
  input  logic [PRG_AW-1:0] prg_load_addr,
  input  logic [7:0]        prg_load_data
);

  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  page_reg, page_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  data_reg;
  logic [7:0]  oam_data_reg;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [7:0]  rom [0:(1<<PRG_AW)-1];

  // The CPU and the DMA engine share one read port: the DMA owns it only in
  // RD, and the CPU bus is ignored for the whole transfer anyway.
  logic [15:0] rd_addr;
  logic        hit_ram, hit_rom;
  logic [7:0]  rd_byte;
  logic        ram_we;
  logic        unused_addr_bits;

  assign rd_addr = (state_reg == RD) ? {page_reg, idx_reg} : Addr_bus;
  assign hit_ram = (rd_addr[15:13] == 3'b000);
  assign hit_rom = rd_addr[15];
  // Upper address bits above each memory's index are don't-care mirrors.
  assign unused_addr_bits = ^rd_addr;

  always_comb begin
    rd_byte = 8'h00;
    if (hit_ram)
      rd_byte = ram[rd_addr[RAM_AW-1:0]];
    else if (hit_rom)
      rd_byte = rom[rd_addr[PRG_AW-1:0]];
  end

  // CPU RAM writes only land while no DMA is running.
  assign ram_we = !rst && (state_reg == IDLE) && !cpu_rw &&
                  (Addr_bus[15:13] == 3'b000);

  always_ff @(posedge clk_ph2) begin
    if (ram_we)
      ram[Addr_bus[RAM_AW-1:0]] <= cpu_dout;
  end

  // Side-port load; a CPU read of the same index this cycle sees the old byte
  // because the read above samples the array before this update.
  always_ff @(posedge clk_ph2) begin
    if (prg_load_we)
      rom[prg_load_addr] <= prg_load_data;
  end

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      data_reg     <= 8'h00;
      oam_data_reg <= 8'h00;
    end else begin
      if ((state_reg == IDLE) && cpu_rw)
        data_reg <= rd_byte;
      if (state_reg == RD)
        oam_data_reg <= rd_byte;
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      state_reg <= IDLE;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (!cpu_rw && (Addr_bus == DMA_REG)) begin
          state_next = ALIGN;
          page_next  = cpu_dout;
        end
      end
      ALIGN: begin
        idx_next   = 8'h00;
        state_next = RD;
      end
      RD: begin
        state_next = WR;
      end
      WR: begin
        // The copy stays inside the source page: index FF is the last byte.
        if (idx_reg == 8'hFF) begin
          state_next = IDLE;
        end else begin
          idx_next   = idx_reg + 8'h01;
          state_next = RD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Data_bus = data_reg;
  assign cpu_rdy  = (state_reg == IDLE);
  assign dma_busy = (state_reg != IDLE);
  assign oam_we   = (state_reg == WR);
  assign oam_addr = idx_reg;
  assign oam_data = oam_data_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        clk_ph2 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr_bus = 16'h2000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  Data_bus;
  logic        cpu_rdy;
  logic        dma_busy;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        prg_load_we = 1'b0;
  logic [13:0] prg_load_addr = 14'h0;
  logic [7:0]  prg_load_data = 8'h00;

  cpu_mem_responder dut (
    .clk_ph2(clk_ph2), .rst(rst), .Addr_bus(Addr_bus), .cpu_rw(cpu_rw),
    .cpu_dout(cpu_dout), .Data_bus(Data_bus), .cpu_rdy(cpu_rdy),
    .dma_busy(dma_busy), .oam_addr(oam_addr), .oam_data(oam_data),
    .oam_we(oam_we), .prg_load_we(prg_load_we), .prg_load_addr(prg_load_addr),
    .prg_load_data(prg_load_data)
  );

  always #5 clk_ph2 = ~clk_ph2;

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks memory contents and counts cycles since a DMA trigger:
  // n=1 is the alignment cycle, odd n>=3 are the 256 OAM write cycles,
  // the CPU is stalled for n=1..513.
  logic [7:0] ram_m [0:2047];
  logic [7:0] rom_m [0:16383];
  int         dma_n = 0;
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_oaddr = 8'h00;
  logic [7:0] m_odata = 8'h00;
  logic       model_ok = 1'b0;

  function automatic logic [7:0] mdec(input logic [15:0] a);
    if (a[15:13] == 3'b000) return ram_m[a[10:0]];
    else if (a[15])         return rom_m[a[13:0]];
    else                    return 8'h00;
  endfunction

  always @(posedge clk_ph2) begin
    if (prg_load_we) rom_m[prg_load_addr] <= prg_load_data;
    if (rst) begin
      model_ok <= 1'b1;
      dma_n    <= 0;
      m_data   <= 8'h00;
    end else if (dma_n == 0) begin
      if (cpu_rw) m_data <= mdec(Addr_bus);
      else begin
        if (Addr_bus[15:13] == 3'b000) ram_m[Addr_bus[10:0]] <= cpu_dout;
        if (Addr_bus == 16'h4014) begin
          dma_n  <= 1;
          m_page <= cpu_dout;
        end
      end
    end else if (dma_n == 513) begin
      dma_n <= 0;
    end else begin
      dma_n <= dma_n + 1;
      if (dma_n % 2 == 0) begin
        m_oaddr <= 8'((dma_n - 2) / 2);
        m_odata <= mdec({m_page, 8'((dma_n - 2) / 2)});
      end
    end
  end

  always @(negedge clk_ph2) begin
    if (model_ok) begin
      chk("cpu_rdy",  16'(cpu_rdy),  16'(dma_n == 0));
      chk("dma_busy", 16'(dma_busy), 16'(dma_n != 0));
      chk("oam_we",   16'(oam_we),   16'(dma_n >= 3 && dma_n % 2 == 1));
      chk("Data_bus", 16'(Data_bus), 16'(m_data));
      if (dma_n >= 3 && dma_n % 2 == 1) begin
        chk("oam_addr", 16'(oam_addr), 16'(m_oaddr));
        chk("oam_data", 16'(oam_data), 16'(m_odata));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d);
    Addr_bus = a; cpu_rw = rw; cpu_dout = d;
    @(negedge clk_ph2);
  endtask

  task automatic idle();
    step(16'h2000, 1'b1, 8'h00);
  endtask

  task automatic load_rom(input logic [13:0] a, input logic [7:0] d);
    prg_load_we = 1'b1; prg_load_addr = a; prg_load_data = d;
    idle();
    prg_load_we = 1'b0;
  endtask

  function automatic logic [7:0] page0_byte(input logic [7:0] a);
    if (a == 8'h03) return 8'h5A;
    return 8'(a * 3);
  endfunction

  // mode 0: data = addr^FF, mode 1: data = 0, mode 2: page-0 pattern.
  task automatic run_dma(input int mode, input logic interfere,
                         output int low, output int pulses, output int bad);
    int k;
    logic [7:0] exp_d;
    low = 0; pulses = 0; bad = 0; k = 0;
    while (cpu_rdy !== 1'b1 && k < 1000) begin
      low++;
      if (oam_we === 1'b1) begin
        case (mode)
          0:       exp_d = oam_addr ^ 8'hFF;
          1:       exp_d = 8'h00;
          default: exp_d = page0_byte(oam_addr);
        endcase
        if (oam_addr !== 8'(pulses) || oam_data !== exp_d) bad++;
        pulses++;
      end
      prg_load_we = 1'b0;
      Addr_bus = 16'h2000; cpu_rw = 1'b1; cpu_dout = 8'h00;
      if (interfere && k == 10) begin Addr_bus = 16'h0010; cpu_rw = 1'b0; cpu_dout = 8'h77; end
      if (interfere && k == 20) begin Addr_bus = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h02; end
      if (interfere && k == 30) begin
        prg_load_we = 1'b1; prg_load_addr = 14'h0005; prg_load_data = 8'h66;
      end
      @(negedge clk_ph2);
      k++;
    end
    prg_load_we = 1'b0;
    $display("dma mode %0d: stall %0d cycles, %0d oam writes, %0d bad", mode, low, pulses, bad);
  endtask

  int low, pulses, bad;

  initial begin
    repeat (2) @(negedge clk_ph2);
    chk("rst_rdy",      16'(cpu_rdy),  16'h1);
    chk("rst_busy",     16'(dma_busy), 16'h0);
    chk("rst_we",       16'(oam_we),   16'h0);
    chk("rst_data",     16'(Data_bus), 16'h0);
    chk("rst_oam_addr", 16'(oam_addr), 16'h0);
    chk("rst_oam_data", 16'(oam_data), 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) step(16'(i), 1'b0, 8'(i * 3));
    for (int i = 0; i < 256; i++) step(16'h0200 + 16'(i), 1'b0, 8'(i) ^ 8'hFF);
    $display("ram filled");

    load_rom(14'h3FFC, 8'h34);
    load_rom(14'h3FFD, 8'h12);
    load_rom(14'h0000, 8'hC3);
    step(16'hFFFC, 1'b1, 8'h00); chk("rd_FFFC", 16'(Data_bus), 16'h34); $display("read FFFC -> %h", Data_bus);
    step(16'hFFFD, 1'b1, 8'h00); chk("rd_FFFD", 16'(Data_bus), 16'h12); $display("read FFFD -> %h", Data_bus);
    step(16'hBFFC, 1'b1, 8'h00); chk("rd_BFFC", 16'(Data_bus), 16'h34); $display("read BFFC -> %h", Data_bus);
    step(16'h8000, 1'b0, 8'hAA);
    step(16'h8000, 1'b1, 8'h00); chk("rom_wr_ignored", 16'(Data_bus), 16'hC3); $display("read 8000 -> %h", Data_bus);

    // load and read of the same ROM index in one cycle: old byte wins
    prg_load_we = 1'b1; prg_load_addr = 14'h3FFC; prg_load_data = 8'h99;
    step(16'hFFFC, 1'b1, 8'h00); prg_load_we = 1'b0;
    chk("load_same_old", 16'(Data_bus), 16'h34); $display("read FFFC during load -> %h", Data_bus);
    step(16'hFFFC, 1'b1, 8'h00); chk("load_same_new", 16'(Data_bus), 16'h99); $display("read FFFC after load -> %h", Data_bus);

    step(16'h0003, 1'b0, 8'h5A);
    step(16'h0803, 1'b1, 8'h00); chk("rd_0803", 16'(Data_bus), 16'h5A); $display("read 0803 -> %h", Data_bus);
    step(16'h1803, 1'b1, 8'h00); chk("rd_1803", 16'(Data_bus), 16'h5A); $display("read 1803 -> %h", Data_bus);
    step(16'h2000, 1'b1, 8'h00); chk("rd_2000", 16'(Data_bus), 16'h00); $display("read 2000 -> %h", Data_bus);
    step(16'h0803, 1'b1, 8'h00);
    step(16'h5000, 1'b1, 8'h00); chk("rd_5000", 16'(Data_bus), 16'h00); $display("read 5000 -> %h", Data_bus);

    // full DMA from page 2 with CPU interference and a mid-DMA ROM load
    step(16'h4014, 1'b0, 8'h02);
    run_dma(0, 1'b1, low, pulses, bad);
    chk("dma2_stall",  16'(low),    16'd513);
    chk("dma2_pulses", 16'(pulses), 16'd256);
    chk("dma2_bad",    16'(bad),    16'd0);
    step(16'h0010, 1'b1, 8'h00); chk("ram_0010_kept", 16'(Data_bus), 16'h30); $display("read 0010 -> %h", Data_bus);
    step(16'h8005, 1'b1, 8'h00); chk("load_during_dma", 16'(Data_bus), 16'h66); $display("read 8005 -> %h", Data_bus);
    repeat (4) idle();
    chk("no_retrigger", 16'(dma_busy), 16'h0);

    // DMA from unmapped page
    step(16'h4014, 1'b0, 8'h60);
    run_dma(1, 1'b0, low, pulses, bad);
    chk("dma60_stall",  16'(low),    16'd513);
    chk("dma60_pulses", 16'(pulses), 16'd256);
    chk("dma60_bad",    16'(bad),    16'd0);

    // reset in the middle of a DMA, then a full restart from page 0
    step(16'hFFFD, 1'b1, 8'h00);
    step(16'h4014, 1'b0, 8'h00);
    repeat (99) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mid_rst_rdy",      16'(cpu_rdy),  16'h1);
    chk("mid_rst_busy",     16'(dma_busy), 16'h0);
    chk("mid_rst_we",       16'(oam_we),   16'h0);
    chk("mid_rst_data",     16'(Data_bus), 16'h0);
    chk("mid_rst_oam_addr", 16'(oam_addr), 16'h0);
    $display("reset mid-dma: rdy=%b busy=%b we=%b data=%h", cpu_rdy, dma_busy, oam_we, Data_bus);
    step(16'h4014, 1'b0, 8'h00);
    run_dma(2, 1'b0, low, pulses, bad);
    chk("dma0_stall",  16'(low),    16'd513);
    chk("dma0_pulses", 16'(pulses), 16'd256);
    chk("dma0_bad",    16'(bad),    16'd0);
    repeat (3) idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
